alu_op_sequencer: RTL and testbench

//  Parametrised control sequencer that runs one register-to-register ALU instruction on the datapath.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/onehot_decoder.sv | 18 +
 rtl/alu_op_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, sequencer states and opcode classification helpers
// for the register-to-register ALU instruction sequencer.
package alu_seq_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR  = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHL = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROR = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROL = 5'b01010;
    localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT = 5'b10010;

    typedef enum logic [2:0] {IDLE, T3, T4, T5, T6, DONE} state_t;

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    // Wide results land in HI/LO instead of a general register.
    function automatic logic is_wide(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_known(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_MUL, OP_DIV, OP_NEG, OP_NOT: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Register index to one-hot select vector; out-of-range indices yield all zeros.
// Purely combinational, no handshake.
module onehot_decoder #(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] i_idx,
    output logic [NUM_REGS-1:0]  o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(i_idx) == i) o_onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Steps one ALU instruction through T3..T6 datapath controls, then pulses done.
// Outputs are a registered decode of the state, so they trail the state by one cycle.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int REG_IDX_W   = 5,
    parameter int OPCODE_W    = 5,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [REG_IDX_W-1:0] ra,
    input  logic [REG_IDX_W-1:0] rb,
    input  logic [REG_IDX_W-1:0] rc,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NUM_REGS-1:0]  rin,
    output logic [NUM_REGS-1:0]  rout,
    output logic                 yin,
    output logic                 zin,
    output logic                 zlo_out,
    output logic                 zhi_out,
    output logic                 hi_in,
    output logic                 lo_in,
    output logic [OPCODE_W-1:0]  alu_opcode
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

    state_t                r_state;
    logic [HOLD_W-1:0]     r_hold;
    logic [OPCODE_W-1:0]   r_op;
    logic [REG_IDX_W-1:0]  r_ra, r_rb, r_rc;
    logic                  r_rej;
    logic                  r_busy, r_done, r_err;
    logic                  r_yin, r_zin, r_zlo_out, r_zhi_out, r_hi_in, r_lo_in;
    logic [NUM_REGS-1:0]   r_rin, r_rout;
    logic [OPCODE_W-1:0]   r_alu_opcode;

    logic [OP_W-1:0]       w_in_op, w_op;
    logic                  w_unary, w_wide, w_accept, w_reject;
    logic [REG_IDX_W-1:0]  w_rout_idx;
    logic [NUM_REGS-1:0]   w_rin_oh, w_rout_oh;
    state_t                w_next;

    function automatic logic idx_bad(input logic [REG_IDX_W-1:0] idx);
        return int'(idx) >= NUM_REGS;
    endfunction

    assign w_in_op  = OP_W'(opcode);
    assign w_op     = OP_W'(r_op);
    assign w_unary  = is_unary(w_op);
    assign w_wide   = is_wide(w_op);
    // r_busy also covers the done cycle, so a start coincident with done is refused.
    assign w_accept = (r_state == IDLE) && start && !r_busy;
    assign w_reject = !is_known(w_in_op) || idx_bad(ra) || idx_bad(rb) ||
                      (!is_unary(w_in_op) && idx_bad(rc));

    assign w_rout_idx = (r_state == T4 && !w_unary) ? r_rc : r_rb;

    always_comb begin
        w_next = DONE;
        case (r_state)
            T3:      w_next = T4;
            T4:      w_next = T5;
            T5:      w_next = w_wide ? T6 : DONE;
            default: w_next = DONE;
        endcase
    end

    onehot_decoder #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_rin_dec (
        .i_idx    (r_ra),
        .o_onehot (w_rin_oh)
    );

    onehot_decoder #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_rout_dec (
        .i_idx    (w_rout_idx),
        .o_onehot (w_rout_oh)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_op         <= '0;
            r_ra         <= '0;
            r_rb         <= '0;
            r_rc         <= '0;
            r_rej        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_yin        <= 1'b0;
            r_zin        <= 1'b0;
            r_zlo_out    <= 1'b0;
            r_zhi_out    <= 1'b0;
            r_hi_in      <= 1'b0;
            r_lo_in      <= 1'b0;
            r_rin        <= '0;
            r_rout       <= '0;
            r_alu_opcode <= '0;
        end else begin
            r_yin        <= (r_state == T3);
            r_zin        <= (r_state == T4);
            r_zlo_out    <= (r_state == T5);
            r_lo_in      <= (r_state == T5) && w_wide;
            r_zhi_out    <= (r_state == T6);
            r_hi_in      <= (r_state == T6);
            r_rin        <= (r_state == T5 && !w_wide) ? w_rin_oh : '0;
            r_rout       <= (r_state == T3 || r_state == T4) ? w_rout_oh : '0;
            r_alu_opcode <= (r_state == T4 || r_state == T5 || r_state == T6) ? r_op : '0;
            r_done       <= (r_state == DONE);
            r_err        <= (r_state == DONE) && r_rej;

            if (w_accept)    r_busy <= 1'b1;
            else if (r_done) r_busy <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= opcode;
                        r_ra    <= ra;
                        r_rb    <= rb;
                        r_rc    <= rc;
                        r_rej   <= w_reject;
                        r_hold  <= w_reject ? '0 : HOLD_INIT;
                        r_state <= w_reject ? DONE : (is_unary(w_in_op) ? T4 : T3);
                    end
                end
                T3, T4, T5, T6: begin
                    if (r_hold == '0) begin
                        r_state <= w_next;
                        r_hold  <= (w_next == DONE) ? '0 : HOLD_INIT;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign rin        = r_rin;
    assign rout       = r_rout;
    assign yin        = r_yin;
    assign zin        = r_zin;
    assign zlo_out    = r_zlo_out;
    assign zhi_out    = r_zhi_out;
    assign hi_in      = r_hi_in;
    assign lo_in      = r_lo_in;
    assign alu_opcode = r_alu_opcode;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: three sequencer instances (default, HOLD_CYCLES=3, NUM_REGS=8) on shared stimulus.
module tb_alu_op_sequencer;

    logic       clk, clr, start;
    logic [4:0] opcode, ra, rb, rc;

    logic        busy1, done1, err1, yin1, zin1, zlo1, zhi1, hi1, lo1;
    logic [15:0] rin1, rout1;
    logic [4:0]  op1;
    logic        busy3, done3, err3, yin3, zin3, zlo3, zhi3, hi3, lo3;
    logic [15:0] rin3, rout3;
    logic [4:0]  op3;
    logic        busy8, done8, err8, yin8, zin8, zlo8, zhi8, hi8, lo8;
    logic [7:0]  rin8, rout8;
    logic [4:0]  op8;

    logic [45:0] o1, o3, o8, exp_v;
    int total = 0;
    int bad   = 0;

    alu_op_sequencer #(.NUM_REGS(16), .REG_IDX_W(5), .OPCODE_W(5), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode), .ra(ra), .rb(rb), .rc(rc),
        .busy(busy1), .done(done1), .err(err1), .rin(rin1), .rout(rout1), .yin(yin1),
        .zin(zin1), .zlo_out(zlo1), .zhi_out(zhi1), .hi_in(hi1), .lo_in(lo1), .alu_opcode(op1));

    alu_op_sequencer #(.NUM_REGS(16), .REG_IDX_W(5), .OPCODE_W(5), .HOLD_CYCLES(3)) dut3 (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode), .ra(ra), .rb(rb), .rc(rc),
        .busy(busy3), .done(done3), .err(err3), .rin(rin3), .rout(rout3), .yin(yin3),
        .zin(zin3), .zlo_out(zlo3), .zhi_out(zhi3), .hi_in(hi3), .lo_in(lo3), .alu_opcode(op3));

    alu_op_sequencer #(.NUM_REGS(8), .REG_IDX_W(5), .OPCODE_W(5), .HOLD_CYCLES(1)) dut8 (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode), .ra(ra), .rb(rb), .rc(rc),
        .busy(busy8), .done(done8), .err(err8), .rin(rin8), .rout(rout8), .yin(yin8),
        .zin(zin8), .zlo_out(zlo8), .zhi_out(zhi8), .hi_in(hi8), .lo_in(lo8), .alu_opcode(op8));

    assign o1 = {busy1, done1, err1, yin1, zin1, zlo1, zhi1, hi1, lo1, op1, rin1, rout1};
    assign o3 = {busy3, done3, err3, yin3, zin3, zlo3, zhi3, hi3, lo3, op3, rin3, rout3};
    assign o8 = {busy8, done8, err8, yin8, zin8, zlo8, zhi8, hi8, lo8, op8,
                 8'h00, rin8, 8'h00, rout8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [45:0] mk(input bit b, input bit d, input bit e, input bit y,
                                       input bit z, input bit zl, input bit zh, input bit h,
                                       input bit l, input logic [4:0] op,
                                       input logic [15:0] ri, input logic [15:0] ro);
        return {b, d, e, y, z, zl, zh, h, l, op, ri, ro};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [4:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c);
        opcode = op; ra = a; rb = b; rc = c; start = 1'b1;
    endtask

    task automatic settle();
        start = 1'b0;
        repeat (16) step();
    endtask

    task automatic test_reset();
        clr = 1'b0; start = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
        step(); step();
        total++; if (o1 !== 46'd0) begin bad++; $display("FAIL reset1 got=%h exp=0", o1); end
        total++; if (o3 !== 46'd0) begin bad++; $display("FAIL reset3 got=%h exp=0", o3); end
        total++; if (o8 !== 46'd0) begin bad++; $display("FAIL reset8 got=%h exp=0", o8); end
        clr = 1'b1;
        step();
        total++; if (o1 !== 46'd0) begin bad++; $display("FAIL idle1 got=%h exp=0", o1); end
    endtask

    task automatic test_add();
        kick(5'b00011, 5'd5, 5'd2, 5'd4);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) start = 1'b0;
            exp_v = mk(c <= 5, c == 5, 0, c == 2, c == 3, c == 4, 0, 0, 0,
                       (c == 3 || c == 4) ? 5'b00011 : 5'b0,
                       (c == 4) ? 16'h0020 : 16'h0,
                       (c == 2) ? 16'h0004 : (c == 3) ? 16'h0010 : 16'h0);
            total++;
            if (o1 !== exp_v) begin bad++; $display("FAIL add c=%0d got=%h exp=%h", c, o1, exp_v); end
        end
        settle();
    endtask

    task automatic test_mul();
        kick(5'b01111, 5'd0, 5'd3, 5'd1);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) start = 1'b0;
            exp_v = mk(c <= 6, c == 6, 0, c == 2, c == 3, c == 4, c == 5, c == 5, c == 4,
                       (c >= 3 && c <= 5) ? 5'b01111 : 5'b0, 16'h0,
                       (c == 2) ? 16'h0008 : (c == 3) ? 16'h0002 : 16'h0);
            total++;
            if (o1 !== exp_v) begin bad++; $display("FAIL mul c=%0d got=%h exp=%h", c, o1, exp_v); end
        end
        settle();
    endtask

    task automatic test_not();
        kick(5'b10010, 5'd7, 5'd6, 5'd0);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) start = 1'b0;
            exp_v = mk(c <= 4, c == 4, 0, 0, c == 2, c == 3, 0, 0, 0,
                       (c == 2 || c == 3) ? 5'b10010 : 5'b0,
                       (c == 3) ? 16'h0080 : 16'h0, (c == 2) ? 16'h0040 : 16'h0);
            total++;
            if (o1 !== exp_v) begin bad++; $display("FAIL not c=%0d got=%h exp=%h", c, o1, exp_v); end
        end
        settle();
    endtask

    task automatic test_same_reg();
        kick(5'b00100, 5'd3, 5'd3, 5'd3);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) start = 1'b0;
            exp_v = mk(c <= 5, c == 5, 0, c == 2, c == 3, c == 4, 0, 0, 0,
                       (c == 3 || c == 4) ? 5'b00100 : 5'b0,
                       (c == 4) ? 16'h0008 : 16'h0,
                       (c == 2 || c == 3) ? 16'h0008 : 16'h0);
            total++;
            if (o1 !== exp_v) begin bad++; $display("FAIL same_reg c=%0d got=%h exp=%h", c, o1, exp_v); end
        end
        settle();
    endtask

    task automatic test_hold3();
        kick(5'b00011, 5'd5, 5'd2, 5'd4);
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c == 1) start = 1'b0;
            exp_v = mk(c <= 11, c == 11, 0, c >= 2 && c <= 4, c >= 5 && c <= 7,
                       c >= 8 && c <= 10, 0, 0, 0,
                       (c >= 5 && c <= 10) ? 5'b00011 : 5'b0,
                       (c >= 8 && c <= 10) ? 16'h0020 : 16'h0,
                       (c >= 2 && c <= 4) ? 16'h0004 : (c >= 5 && c <= 7) ? 16'h0010 : 16'h0);
            total++;
            if (o3 !== exp_v) begin bad++; $display("FAIL hold3 c=%0d got=%h exp=%h", c, o3, exp_v); end
        end
        settle();
    endtask

    task automatic test_back_to_back();
        int k;
        kick(5'b10010, 5'd7, 5'd6, 5'd0);
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 6) start = 1'b0;
            k = (c <= 4) ? c : c - 5;
            exp_v = mk(k >= 1 && k <= 4, k == 4, 0, 0, k == 2, k == 3, 0, 0, 0,
                       (k == 2 || k == 3) ? 5'b10010 : 5'b0,
                       (k == 3) ? 16'h0080 : 16'h0, (k == 2) ? 16'h0040 : 16'h0);
            total++;
            if (o1 !== exp_v) begin bad++; $display("FAIL b2b c=%0d got=%h exp=%h", c, o1, exp_v); end
        end
        settle();
    endtask

    task automatic test_restart_clr();
        kick(5'b00011, 5'd5, 5'd2, 5'd4);
        step(); start = 1'b0;
        step(); start = 1'b1; ra = 5'd9; rb = 5'd1;
        step(); start = 1'b0;
        exp_v = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00011, 16'h0, 16'h0010);
        total++;
        if (o1 !== exp_v) begin bad++; $display("FAIL restart_t4 got=%h exp=%h", o1, exp_v); end
        step();
        exp_v = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00011, 16'h0020, 16'h0);
        total++;
        if (o1 !== exp_v) begin bad++; $display("FAIL restart_t5 got=%h exp=%h", o1, exp_v); end
        #2 clr = 1'b0;
        #1;
        total++;
        if (o1 !== 46'd0) begin bad++; $display("FAIL clr_async got=%h exp=0", o1); end
        step(); step();
        clr = 1'b1;
        step(); step();
        total++;
        if (o1 !== 46'd0) begin bad++; $display("FAIL clr_idle got=%h exp=0", o1); end
        settle();
    endtask

    task automatic test_reject();
        kick(5'b00011, 5'd1, 5'd2, 5'd9);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) start = 1'b0;
            exp_v = mk(c <= 2, c == 2, c == 2, 0, 0, 0, 0, 0, 0, 5'b0, 16'h0, 16'h0);
            total++;
            if (o8 !== exp_v) begin bad++; $display("FAIL rej_rc c=%0d got=%h exp=%h", c, o8, exp_v); end
        end
        settle();
        kick(5'b00011, 5'd8, 5'd0, 5'd0);
        step(); start = 1'b0;
        step();
        exp_v = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 5'b0, 16'h0, 16'h0);
        total++;
        if (o8 !== exp_v) begin bad++; $display("FAIL rej_ra got=%h exp=%h", o8, exp_v); end
        settle();
        kick(5'b10010, 5'd7, 5'd6, 5'd9);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) start = 1'b0;
            exp_v = mk(c <= 4, c == 4, 0, 0, c == 2, c == 3, 0, 0, 0,
                       (c == 2 || c == 3) ? 5'b10010 : 5'b0,
                       (c == 3) ? 16'h0080 : 16'h0, (c == 2) ? 16'h0040 : 16'h0);
            total++;
            if (o8 !== exp_v) begin bad++; $display("FAIL unary_rc c=%0d got=%h exp=%h", c, o8, exp_v); end
        end
        settle();
    endtask

    task automatic test_bad_opcode();
        kick(5'b01011, 5'd1, 5'd2, 5'd3);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) start = 1'b0;
            exp_v = mk(c <= 2, c == 2, c == 2, 0, 0, 0, 0, 0, 0, 5'b0, 16'h0, 16'h0);
            total++;
            if (o1 !== exp_v) begin bad++; $display("FAIL bad_op c=%0d got=%h exp=%h", c, o1, exp_v); end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_not();
        test_same_reg();
        test_hold3();
        test_back_to_back();
        test_restart_clr();
        test_reject();
        test_bad_opcode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
